exe_div_issue: RTL
==================

EXE_DIV_ISSUE -- requirements
Module: exe_div_issue

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter TIMEOUT, default 64, SHALL set the maximum number of WAIT cycles allowed before the divider is declared hung.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: req_valid  input  1  ID stage presents a divide/remainder instruction.
REQ-006 Port: req_op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 Port: req_rs1 / req_rs2  input  32 each  dividend / divisor.
REQ-008 Port: req_rd  input  5  destination register.
REQ-009 Port: req_ready  output  1  block can accept a request.
REQ-010 Port: div_start  output  1  one-cycle launch pulse to the iterative divider.
REQ-011 Port: div_a / div_b  output  32 each  unsigned magnitudes sent to the divider.
REQ-012 Port: div_valid  input  1  divider result ready.
REQ-013 Port: div_q / div_r  input  32 each  unsigned quotient / remainder.
REQ-014 Port: stall  output  1  freeze upstream pipeline.
REQ-015 Port: wb_valid / wb_rd / wb_data  output  1/5/32  writeback request.
REQ-016 Port: wb_ready  input  1  writeback accepts.
REQ-017 Port: err  output  1  one-cycle divider-timeout pulse.

Function
REQ-018 The FSM SHALL have the states IDLE, LAUNCH, WAIT, FIX and WB.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge where req_valid and req_ready are both 1.
REQ-020 On acceptance, the block SHALL latch op, rs1, rs2 and rd.
REQ-021 On acceptance with rs2==0, the block SHALL go to WB without launching the divider, with wb_data = 0xFFFFFFFF for DIV/DIVU and wb_data = rs1 for REM/REMU.
REQ-022 On acceptance with a signed op, rs1==0x80000000 and rs2==0xFFFFFFFF, the block SHALL go to WB without launching the divider, with wb_data = 0x80000000 for DIV and 0 for REM.
REQ-023 On any other acceptance, the block SHALL go to LAUNCH.
REQ-024 In LAUNCH, div_start SHALL be 1 for exactly one cycle and the state SHALL then go to WAIT.
REQ-025 div_a/div_b SHALL hold the operand magnitudes from LAUNCH until leaving WAIT: the absolute value for signed ops, the raw value for unsigned ops, with |0x80000000| = 0x80000000.
REQ-026 In WAIT, a 7-bit counter SHALL increment each cycle; when div_valid is sampled 1, div_q/div_r SHALL be latched and the state SHALL go to FIX.
REQ-027 If the WAIT counter reaches TIMEOUT without div_valid, the block SHALL pulse err for one cycle and go to WB with wb_data = 0.
REQ-028 FIX SHALL last one cycle and apply sign correction: DIV result negated when the rs1 and rs2 signs differ; REM result takes the sign of rs1; unsigned ops unchanged; all arithmetic in 32-bit two's complement.
REQ-029 FIX SHALL then go to WB.
REQ-030 In WB, wb_valid SHALL be 1 and wb_rd/wb_data SHALL be held stable until wb_ready is 1; the state then returns to IDLE in the next cycle.
REQ-031 stall SHALL be 1 in every state except IDLE, and also in IDLE when req_valid=1 in the cycle of acceptance.
REQ-032 div_valid SHALL be ignored outside WAIT.
REQ-033 div_valid and the timeout occurring in the same cycle SHALL be treated as div_valid (result wins).
REQ-034 Latency SHALL be: bypass path wb_valid one cycle after acceptance; normal path wb_valid = acceptance + 1 (LAUNCH) + WAIT length + 1 (FIX) + 1.

Reset
REQ-035 While rst=1, the state SHALL go to IDLE and all outputs SHALL be 0 except req_ready, which is 1.
REQ-036 Latched operands and the counter SHALL be cleared on reset.
REQ-037 Reset mid-operation SHALL abandon the in-flight request with no wb_valid and no err.
REQ-038 A div_valid arriving after reset SHALL be ignored.

Verification
REQ-039 Bench scenario: DIV rs1=-7 (0xFFFFFFF9), rs2=2, divider returns q=3 r=1 after 40 cycles -> wb_data=0xFFFFFFFD, single div_start, stall high throughout.
REQ-040 Bench scenario: REM rs1=-7, rs2=2 -> wb_data=0xFFFFFFFF; REMU rs1=7, rs2=2 -> wb_data=1.
REQ-041 Bench scenario: DIVU rs2=0 -> wb_data=0xFFFFFFFF one cycle after acceptance, div_start never asserted.
REQ-042 Bench scenario: DIV 0x80000000 / 0xFFFFFFFF -> wb_data=0x80000000 with no launch; REM of the same operands -> 0.
REQ-043 Bench scenario: divider never responds -> err pulses once TIMEOUT=64 cycles into WAIT and wb_data=0; a late div_valid is ignored.
REQ-044 Bench scenario: wb_ready held low for 5 cycles in WB -> wb_valid/wb_rd/wb_data stable; a second req_valid is not accepted until the block returns to IDLE; rst asserted in WAIT -> no writeback produced.

Source files
------------

// File: rtl/exe_div_issue.sv
// Issue/writeback sequencer for an external iterative divider.
// Handles RISC-V DIV/DIVU/REM/REMU: bypasses divide-by-zero and signed overflow,
// sends operand magnitudes to the divider, applies sign correction on the result,
// and times out a divider that never answers.
module exe_div_issue #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [4:0]  req_rd,
    output logic        req_ready,
    output logic        div_start,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_valid,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    input  logic        wb_ready,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        FIX,
        WB
    } state_t;

    // Last WAIT count before the divider is declared hung.
    localparam logic [6:0] LAST_CNT = 7'(TIMEOUT - 1);

    state_t      state_q;
    logic [1:0]  op_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [4:0]  rd_q;
    logic [6:0]  cnt_q;
    logic [31:0] q_q;
    logic [31:0] r_q;
    logic        req_ready_q;
    logic        div_start_q;
    logic        wb_valid_q;
    logic [31:0] wb_data_q;
    logic        err_q;

    // op[0] = unsigned, op[1] = remainder.
    logic        req_bypass;
    logic [31:0] bypass_data;
    logic        op_signed;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        res_neg;
    logic [31:0] res_mag;
    logic [31:0] fix_data;

    // Decode special-case requests that never reach the divider.
    always_comb begin
        logic div_zero;
        logic ovf;
        div_zero    = (req_rs2 == '0);
        ovf         = !req_op[0] && (req_rs1 == 32'h8000_0000) && (req_rs2 == '1);
        req_bypass  = div_zero || ovf;
        bypass_data = '0;
        if (div_zero) begin
            bypass_data = req_op[1] ? req_rs1 : '1;
        end else if (ovf) begin
            bypass_data = req_op[1] ? 32'h0 : 32'h8000_0000;
        end
    end

    // Operand magnitudes and signed result correction from the latched request.
    always_comb begin
        op_signed = !op_q[0];
        mag_a     = (op_signed && rs1_q[31]) ? -rs1_q : rs1_q;
        mag_b     = (op_signed && rs2_q[31]) ? -rs2_q : rs2_q;
        res_mag   = op_q[1] ? r_q : q_q;
        res_neg   = op_signed && (op_q[1] ? rs1_q[31] : (rs1_q[31] ^ rs2_q[31]));
        fix_data  = res_neg ? -res_mag : res_mag;
    end

    // Control FSM with registered handshake, launch, writeback and error outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            q_q         <= '0;
            r_q         <= '0;
            req_ready_q <= 1'b1;
            div_start_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            div_start_q <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q        <= req_op;
                        rs1_q       <= req_rs1;
                        rs2_q       <= req_rs2;
                        rd_q        <= req_rd;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        if (req_bypass) begin
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= bypass_data;
                            state_q    <= WB;
                        end else begin
                            div_start_q <= 1'b1;
                            state_q     <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A result in the timeout cycle still takes priority.
                    if (div_valid) begin
                        q_q     <= div_q;
                        r_q     <= div_r;
                        state_q <= FIX;
                    end else if (cnt_q == LAST_CNT) begin
                        err_q      <= 1'b1;
                        wb_valid_q <= 1'b1;
                        wb_data_q  <= '0;
                        state_q    <= WB;
                    end else begin
                        cnt_q <= cnt_q + 7'd1;
                    end
                end
                FIX: begin
                    wb_valid_q <= 1'b1;
                    wb_data_q  <= fix_data;
                    state_q    <= WB;
                end
                WB: begin
                    if (wb_ready) begin
                        wb_valid_q  <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign div_start = div_start_q;
    assign div_a     = ((state_q == LAUNCH) || (state_q == WAIT)) ? mag_a : '0;
    assign div_b     = ((state_q == LAUNCH) || (state_q == WAIT)) ? mag_b : '0;
    // Acceptance cycle stalls too, so the upstream stage holds while the request is taken.
    assign stall     = (state_q != IDLE) || (req_valid && !rst);
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = rd_q;
    assign wb_data   = wb_data_q;
    assign err       = err_q;

endmodule
